// File: rtl/playlist_mcu_if.sv
// Purpose : request/control/player bundle between the front end, playlist_mcu and the song player.
// Latency : none; this is wiring only.
// Backpressure: none. Requests arriving while the queue is full are dropped and flagged via overflow.
// Ports   : master = front end / player side (drives requests and song_done);
//           slave  = playlist_mcu (drives play, reset_player, song and queue status).
interface playlist_mcu_if #(
  parameter int SONG_W = 4,
  parameter int CNT_W  = 3
);
  logic              req_valid;
  logic [SONG_W-1:0] req_song;
  logic              skip;
  logic              pause_toggle;
  logic              repeat_mode;
  logic              song_done;
  logic              play;
  logic              reset_player;
  logic [SONG_W-1:0] song;
  logic [CNT_W-1:0]  queue_count;
  logic              queue_full;
  logic              overflow;

  modport master (
    output req_valid, req_song, skip, pause_toggle, repeat_mode, song_done,
    input  play, reset_player, song, queue_count, queue_full, overflow
  );

  modport slave (
    input  req_valid, req_song, skip, pause_toggle, repeat_mode, song_done,
    output play, reset_player, song, queue_count, queue_full, overflow
  );
endinterface

// File: rtl/playlist_mcu.sv
// Purpose : FIFO playlist that sequences a song player one song at a time (IDLE/LOAD/PLAYING/PAUSED).
// Latency : request into an idle, empty controller gives song after 2 edges, reset_player in the LOAD cycle, and play on the edge after that.
// Backpressure: none. A request into a full queue with no pop in the same cycle is dropped and sets sticky overflow.
// Ports   : clk, reset (async, active low), bus (playlist_mcu_if.slave: req_valid/req_song/skip/
//           pause_toggle/repeat_mode/song_done in; play/reset_player/song/queue_count/queue_full/overflow out).
// Option  : define REPEAT_MODE_EN to re-queue finished songs while repeat_mode=1; otherwise repeat_mode is ignored.
module playlist_mcu #(
  parameter int SONG_W      = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  playlist_mcu_if.slave  bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PLAYING = 2'd2,
    PAUSED  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [SONG_W-1:0] mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              full_q, ovf_q;
  logic [SONG_W-1:0] song_q, song_nxt;
  logic              q_empty;
  logic              pop, rep_push, user_push, drop;
  logic [CNT_W:0]    occ_after;
  logic              rep_req;

`ifdef REPEAT_MODE_EN
  assign rep_req = bus.song_done && bus.repeat_mode;
`else
  // Repeat is compiled out; the input stays connected but has no effect.
  logic unused_repeat;
  assign rep_req       = 1'b0;
  assign unused_repeat = bus.repeat_mode;
`endif

  // Registered count is used on purpose: a request pushed this cycle is
  // not visible to the pop decision until the following cycle.
  assign q_empty = (count == '0);

  // Next-state, pop and repeat decisions.
  always_comb begin
    state_nxt = state;
    song_nxt  = song_q;
    pop       = 1'b0;
    rep_push  = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          pop       = 1'b1;
          song_nxt  = mem[rd_ptr];
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = PLAYING;
      end
      PLAYING: begin
        // Advancing outranks pause_toggle in the same cycle.
        if (bus.song_done || bus.skip) begin
          if (!q_empty) begin
            pop       = 1'b1;
            song_nxt  = mem[rd_ptr];
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
          // A finished song goes to the tail behind the pop. With an empty
          // queue it simply reloads in place instead of bouncing via IDLE.
          if (rep_req) begin
            if (!q_empty) rep_push  = 1'b1;
            else          state_nxt = LOAD;
          end
        end else if (bus.pause_toggle) begin
          state_nxt = PAUSED;
        end
      end
      PAUSED: begin
        // song_done is ignored here; skip never re-queues.
        if (bus.skip) begin
          if (!q_empty) begin
            pop       = 1'b1;
            song_nxt  = mem[rd_ptr];
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else if (bus.pause_toggle) begin
          state_nxt = PLAYING;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slot accounting: the repeat push claims its slot before a user request.
  always_comb begin
    occ_after = {1'b0, count} - (CNT_W+1)'(pop) + (CNT_W+1)'(rep_push);
    user_push = bus.req_valid && (occ_after < (CNT_W+1)'(QUEUE_DEPTH));
    drop      = bus.req_valid && !user_push;
    count_nxt = CNT_W'(occ_after + (CNT_W+1)'(user_push));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      song_q <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      song_q <= song_nxt;
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(rep_push) + PTR_W'(user_push);
      count  <= count_nxt;
      full_q <= (count_nxt == CNT_W'(QUEUE_DEPTH));
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read behind valid pointers.
  always_ff @(posedge clk) begin
    if (rep_push)  mem[wr_ptr] <= song_q;
    if (user_push) mem[wr_ptr + PTR_W'(rep_push)] <= bus.req_song;
  end

  assign bus.play         = (state == PLAYING);
  assign bus.reset_player = (state == LOAD);
  assign bus.song         = song_q;
  assign bus.queue_count  = count;
  assign bus.queue_full   = full_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_playlist_mcu.sv
// Purpose : directed self-checking bench for playlist_mcu (SONG_W=4, QUEUE_DEPTH=4).
// Latency : inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Backpressure: not applicable; every run length is fixed and needs no waits on DUT events.
module tb_playlist_mcu;
  localparam int SW = 4;
  localparam int QD = 4;
  localparam int CW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [SW-1:0] fill_a [4];
  logic [SW-1:0] fill_b [4];
  logic [SW-1:0] drain_b [4];

  playlist_mcu_if #(.SONG_W(SW), .CNT_W(CW)) bus ();

  playlist_mcu #(.SONG_W(SW), .QUEUE_DEPTH(QD), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (bus.play !== 1'b0) begin errors++; $display("FAIL rst_play got %0b exp 0", bus.play); end
    checks++; if (bus.reset_player !== 1'b0) begin errors++; $display("FAIL rst_reset_player got %0b exp 0", bus.reset_player); end
    checks++; if (bus.song !== 4'd0) begin errors++; $display("FAIL rst_song got %0d exp 0", bus.song); end
    checks++; if (bus.queue_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.queue_count); end
    checks++; if (bus.queue_full !== 1'b0) begin errors++; $display("FAIL rst_full got %0b exp 0", bus.queue_full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0b exp 0", bus.overflow); end
    reset = 1'b1;
    step();
    checks++; if (bus.play !== 1'b0) begin errors++; $display("FAIL rst_idle_play got %0b exp 0", bus.play); end
  endtask

  task automatic test_single();
    bus.req_valid = 1'b1; bus.req_song = 4'd1;
    step();
    bus.req_valid = 1'b0;
    checks++; if (bus.queue_count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", bus.queue_count); end
    checks++; if (bus.reset_player !== 1'b0) begin errors++; $display("FAIL single_rp_early got %0b exp 0", bus.reset_player); end
    step();
    checks++; if (bus.song !== 4'd1) begin errors++; $display("FAIL single_song got %0d exp 1", bus.song); end
    checks++; if (bus.reset_player !== 1'b1) begin errors++; $display("FAIL single_rp got %0b exp 1", bus.reset_player); end
    checks++; if (bus.play !== 1'b0) begin errors++; $display("FAIL single_play_load got %0b exp 0", bus.play); end
    checks++; if (bus.queue_count !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", bus.queue_count); end
    step();
    checks++; if (bus.play !== 1'b1) begin errors++; $display("FAIL single_play got %0b exp 1", bus.play); end
    checks++; if (bus.reset_player !== 1'b0) begin errors++; $display("FAIL single_rp_end got %0b exp 0", bus.reset_player); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1; bus.req_song = fill_a[i];
      step();
    end
    bus.req_valid = 1'b0;
    checks++; if (bus.queue_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", bus.queue_count); end
    checks++; if (bus.queue_full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b exp 1", bus.queue_full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %0b exp 0", bus.overflow); end
    bus.req_valid = 1'b1; bus.req_song = 4'd9;
    step();
    bus.req_valid = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %0b exp 1", bus.overflow); end
    checks++; if (bus.queue_count !== 3'd4) begin errors++; $display("FAIL fill_count_ovf got %0d exp 4", bus.queue_count); end
    checks++; if (bus.song !== 4'd1 || bus.play !== 1'b1) begin errors++; $display("FAIL fill_playing got song %0d play %0b exp 1/1", bus.song, bus.play); end
  endtask

  task automatic test_done();
    bus.song_done = 1'b1;
    step();
    bus.song_done = 1'b0;
    checks++; if (bus.song !== 4'd5) begin errors++; $display("FAIL done_song got %0d exp 5", bus.song); end
    checks++; if (bus.reset_player !== 1'b1) begin errors++; $display("FAIL done_rp got %0b exp 1", bus.reset_player); end
    checks++; if (bus.queue_count !== 3'd3 || bus.queue_full !== 1'b0) begin errors++; $display("FAIL done_count got %0d/%0b exp 3/0", bus.queue_count, bus.queue_full); end
    step();
    checks++; if (bus.play !== 1'b1) begin errors++; $display("FAIL done_play got %0b exp 1", bus.play); end
    bus.skip = 1'b1;
    step();
    bus.skip = 1'b0;
    checks++; if (bus.song !== 4'd15 || bus.reset_player !== 1'b1) begin errors++; $display("FAIL skip_song got %0d rp %0b exp 15/1", bus.song, bus.reset_player); end
    checks++; if (bus.queue_count !== 3'd2) begin errors++; $display("FAIL skip_count got %0d exp 2", bus.queue_count); end
    step();
    bus.song_done = 1'b1; step(); bus.song_done = 1'b0;
    checks++; if (bus.song !== 4'd3 || bus.queue_count !== 3'd1) begin errors++; $display("FAIL drain3 got %0d cnt %0d exp 3/1", bus.song, bus.queue_count); end
    step();
    bus.song_done = 1'b1; step(); bus.song_done = 1'b0;
    checks++; if (bus.song !== 4'd7 || bus.queue_count !== 3'd0) begin errors++; $display("FAIL drain7 got %0d cnt %0d exp 7/0", bus.song, bus.queue_count); end
    step();
    checks++; if (bus.play !== 1'b1) begin errors++; $display("FAIL drain_play got %0b exp 1", bus.play); end
    bus.song_done = 1'b1; step(); bus.song_done = 1'b0;
    checks++; if (bus.play !== 1'b0 || bus.reset_player !== 1'b0) begin errors++; $display("FAIL idle_out got play %0b rp %0b exp 0/0", bus.play, bus.reset_player); end
    step();
    step();
    checks++; if (bus.play !== 1'b0 || bus.song !== 4'd7) begin errors++; $display("FAIL idle_hold got play %0b song %0d exp 0/7", bus.play, bus.song); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", bus.overflow); end
  endtask

  task automatic test_pause();
    bus.req_valid = 1'b1; bus.req_song = 4'd2;
    step();
    bus.req_song = 4'd4;
    step();
    bus.req_valid = 1'b0;
    checks++; if (bus.song !== 4'd2 || bus.reset_player !== 1'b1) begin errors++; $display("FAIL pz_load got %0d rp %0b exp 2/1", bus.song, bus.reset_player); end
    checks++; if (bus.queue_count !== 3'd1) begin errors++; $display("FAIL pz_count got %0d exp 1", bus.queue_count); end
    step();
    bus.pause_toggle = 1'b1; step(); bus.pause_toggle = 1'b0;
    checks++; if (bus.play !== 1'b0 || bus.song !== 4'd2) begin errors++; $display("FAIL pz_paused got play %0b song %0d exp 0/2", bus.play, bus.song); end
    bus.song_done = 1'b1; step(); bus.song_done = 1'b0;
    checks++; if (bus.play !== 1'b0 || bus.reset_player !== 1'b0 || bus.song !== 4'd2 || bus.queue_count !== 3'd1) begin
      errors++; $display("FAIL pz_done_ignored got play %0b rp %0b song %0d cnt %0d exp 0/0/2/1", bus.play, bus.reset_player, bus.song, bus.queue_count);
    end
    bus.pause_toggle = 1'b1; step(); bus.pause_toggle = 1'b0;
    checks++; if (bus.play !== 1'b1) begin errors++; $display("FAIL pz_resume got %0b exp 1", bus.play); end
    bus.pause_toggle = 1'b1; step(); bus.pause_toggle = 1'b0;
    bus.skip = 1'b1; step(); bus.skip = 1'b0;
    checks++; if (bus.song !== 4'd4 || bus.reset_player !== 1'b1 || bus.queue_count !== 3'd0) begin
      errors++; $display("FAIL pz_skip got song %0d rp %0b cnt %0d exp 4/1/0", bus.song, bus.reset_player, bus.queue_count);
    end
    step();
    checks++; if (bus.play !== 1'b1) begin errors++; $display("FAIL pz_skip_play got %0b exp 1", bus.play); end
    // skip beats pause_toggle: must land in IDLE, where a later toggle does nothing.
    bus.skip = 1'b1; bus.pause_toggle = 1'b1; step(); bus.skip = 1'b0; bus.pause_toggle = 1'b0;
    checks++; if (bus.play !== 1'b0 || bus.song !== 4'd4) begin errors++; $display("FAIL prio_idle got play %0b song %0d exp 0/4", bus.play, bus.song); end
    bus.pause_toggle = 1'b1; step(); bus.pause_toggle = 1'b0;
    checks++; if (bus.play !== 1'b0) begin errors++; $display("FAIL idle_toggle got %0b exp 0", bus.play); end
  endtask

  task automatic test_full_simul();
    reset = 1'b0; step(); reset = 1'b1;
    checks++; if (bus.overflow !== 1'b0 || bus.song !== 4'd0) begin errors++; $display("FAIL fs_reset got ovf %0b song %0d exp 0/0", bus.overflow, bus.song); end
    bus.req_valid = 1'b1; bus.req_song = 4'd1; step(); bus.req_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1; bus.req_song = fill_b[i];
      step();
    end
    bus.req_valid = 1'b0;
    checks++; if (bus.queue_count !== 3'd4 || bus.queue_full !== 1'b1) begin errors++; $display("FAIL fs_full got %0d/%0b exp 4/1", bus.queue_count, bus.queue_full); end
    bus.req_valid = 1'b1; bus.req_song = 4'd12; bus.song_done = 1'b1;
    step();
    bus.req_valid = 1'b0; bus.song_done = 1'b0;
    checks++; if (bus.queue_count !== 3'd4 || bus.queue_full !== 1'b1) begin errors++; $display("FAIL fs_simul_count got %0d/%0b exp 4/1", bus.queue_count, bus.queue_full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fs_simul_ovf got %0b exp 0", bus.overflow); end
    checks++; if (bus.song !== 4'd8 || bus.reset_player !== 1'b1) begin errors++; $display("FAIL fs_simul_song got %0d rp %0b exp 8/1", bus.song, bus.reset_player); end
    for (int i = 0; i < 4; i++) begin
      step();
      bus.skip = 1'b1; step(); bus.skip = 1'b0;
      checks++; if (bus.song !== drain_b[i] || bus.queue_count !== CW'(3 - i)) begin
        errors++; $display("FAIL fs_order[%0d] got song %0d cnt %0d exp %0d/%0d", i, bus.song, bus.queue_count, drain_b[i], 3 - i);
      end
    end
    step();
    bus.skip = 1'b1; step(); bus.skip = 1'b0;
    checks++; if (bus.play !== 1'b0 || bus.song !== 4'd12) begin errors++; $display("FAIL fs_end got play %0b song %0d exp 0/12", bus.play, bus.song); end
  endtask

  task automatic test_repeat();
    bus.repeat_mode = 1'b1;
    bus.req_valid = 1'b1; bus.req_song = 4'd1; step(); bus.req_valid = 1'b0;
    step();
    step();
    bus.song_done = 1'b1; step(); bus.song_done = 1'b0;
`ifdef REPEAT_MODE_EN
    checks++; if (bus.song !== 4'd1 || bus.reset_player !== 1'b1 || bus.queue_count !== 3'd0) begin
      errors++; $display("FAIL rep_reload1 got song %0d rp %0b cnt %0d exp 1/1/0", bus.song, bus.reset_player, bus.queue_count);
    end
    step();
    checks++; if (bus.play !== 1'b1) begin errors++; $display("FAIL rep_play got %0b exp 1", bus.play); end
    bus.song_done = 1'b1; step(); bus.song_done = 1'b0;
    checks++; if (bus.song !== 4'd1 || bus.reset_player !== 1'b1) begin errors++; $display("FAIL rep_reload2 got song %0d rp %0b exp 1/1", bus.song, bus.reset_player); end
    step();
`else
    checks++; if (bus.play !== 1'b0 || bus.reset_player !== 1'b0 || bus.song !== 4'd1) begin
      errors++; $display("FAIL norep_idle got play %0b rp %0b song %0d exp 0/0/1", bus.play, bus.reset_player, bus.song);
    end
    step();
    checks++; if (bus.play !== 1'b0 || bus.reset_player !== 1'b0) begin errors++; $display("FAIL norep_stay got play %0b rp %0b exp 0/0", bus.play, bus.reset_player); end
`endif
    bus.repeat_mode = 1'b0;
    bus.skip = 1'b1; step(); bus.skip = 1'b0;
    checks++; if (bus.play !== 1'b0) begin errors++; $display("FAIL rep_exit got %0b exp 0", bus.play); end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_song = 4'd3; step(); bus.req_valid = 1'b0;
    step();
    step();
    checks++; if (bus.play !== 1'b1 || bus.song !== 4'd3) begin errors++; $display("FAIL mid_pre got play %0b song %0d exp 1/3", bus.play, bus.song); end
    bus.req_valid = 1'b1; bus.req_song = 4'd5; step(); bus.req_valid = 1'b0;
    checks++; if (bus.queue_count !== 3'd1) begin errors++; $display("FAIL mid_count got %0d exp 1", bus.queue_count); end
    reset = 1'b0;
    #1;
    checks++; if (bus.play !== 1'b0 || bus.song !== 4'd0 || bus.reset_player !== 1'b0) begin
      errors++; $display("FAIL mid_async got play %0b song %0d rp %0b exp 0/0/0", bus.play, bus.song, bus.reset_player);
    end
    checks++; if (bus.queue_count !== 3'd0 || bus.queue_full !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL mid_async_q got cnt %0d full %0b ovf %0b exp 0/0/0", bus.queue_count, bus.queue_full, bus.overflow);
    end
    step();
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.play !== 1'b0 || bus.reset_player !== 1'b0 || bus.queue_count !== 3'd0) begin
      errors++; $display("FAIL mid_discard got play %0b rp %0b cnt %0d exp 0/0/0", bus.play, bus.reset_player, bus.queue_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fill_a  = '{4'd5, 4'd15, 4'd3, 4'd7};
    fill_b  = '{4'd8, 4'd9, 4'd10, 4'd11};
    drain_b = '{4'd9, 4'd10, 4'd11, 4'd12};
    reset            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_song     = '0;
    bus.skip         = 1'b0;
    bus.pause_toggle = 1'b0;
    bus.repeat_mode  = 1'b0;
    bus.song_done    = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_done();
    test_pause();
    test_full_simul();
    test_repeat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
